// File: rtl/led_ctrl_multi_if.sv
// Button/LED bundle for led_ctrl_multi: raw buttons and per-channel modes in,
// registered LED drive, toggle state and press pulses out.
interface led_ctrl_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   push;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   led_on;
  logic [N_CH-1:0]   on_state;
  logic [N_CH-1:0]   push_evt;

  modport master (
    output push,
    output mode,
    input  led_on,
    input  on_state,
    input  push_evt
  );

  modport slave (
    input  push,
    input  mode,
    output led_on,
    output on_state,
    output push_evt
  );
endinterface

// File: rtl/led_ctrl_multi.sv
// Multi-channel push-button LED controller: per-channel sync, debounce, edge
// detect and a toggle FSM, with toggle/momentary/blink/off output modes.
module led_ctrl_multi #(
  parameter int N_CH              = 4,
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int BLINK_HALF_CYCLES = 25
) (
  input logic              clk_p,
  input logic              clk_n,
  input logic              rst_n,
  led_ctrl_multi_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_MOMENT = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  logic clk;

  // Behavioural stand-in for the IBUFDS differential receiver.
  assign clk = clk_p & ~clk_n;

  logic [PW-1:0]   pre;
  logic            ph;
  logic            ph_next;
  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] db;
  logic [N_CH-1:0] db_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] evt_q;
  logic [N_CH-1:0] led_q;
  logic [N_CH-1:0] led_next;
  logic [CW-1:0]   cnt     [N_CH];
  state_t          st      [N_CH];
  state_t          st_next [N_CH];

  assign ph_next = (pre == PRE_LAST) ? ~ph : ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      ph  <= 1'b0;
    end else begin
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      ph  <= ph_next;
    end
  end

  // The LED register sees the post-edge state and phase so it moves together with on_state.
  always_comb begin
    mode_t m;
    rise     = db & ~db_d;
    st_next  = st;
    led_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      m = mode_t'(bus.mode[2*i +: 2]);
      case (m)
        MODE_TOGGLE: begin
          if (rise[i]) st_next[i] = (st[i] == ST_ON) ? ST_OFF : ST_ON;
          led_next[i] = (st_next[i] == ST_ON);
        end
        MODE_MOMENT: begin
          led_next[i] = db[i];
        end
        MODE_BLINK: begin
          if (rise[i]) st_next[i] = (st[i] == ST_ON) ? ST_OFF : ST_ON;
          led_next[i] = (st_next[i] == ST_ON) & ph_next;
        end
        default: begin
          st_next[i]  = ST_OFF;
          led_next[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      db    <= '0;
      db_d  <= '0;
      evt_q <= '0;
      led_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
        st[i]  <= ST_OFF;
      end
    end else begin
      s1    <= bus.push;
      s2    <= s1;
      db_d  <= db;
      evt_q <= rise;
      led_q <= led_next;
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= st_next[i];
        // Any return to the accepted level restarts the stability count.
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.on_state = '0;
    for (int i = 0; i < N_CH; i++) bus.on_state[i] = (st[i] == ST_ON);
  end

  assign bus.led_on   = led_q;
  assign bus.push_evt = evt_q;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Self-checking bench for led_ctrl_multi (4 channels, debounce 4, blink half 5):
// a per-cycle scoreboard fed by a reference model plus directed timing checks.
module tb_led_ctrl_multi;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int BH = 5;

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] on;
    logic [3:0] evt;
  } exp_t;

  logic clk_p = 1'b0;
  logic clk_n = 1'b1;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int edge_num = 0;
  int evt_cnt [N];
  int base;
  int snap;

  exp_t exp_q[$];

  logic [3:0] m_s1, m_s2, m_db, m_dbd, m_on, m_led, m_evt;
  int         m_cnt [N];
  int         m_pre;
  logic       m_ph;

  led_ctrl_multi_if #(.N_CH(N)) bus ();

  led_ctrl_multi #(
    .N_CH(N),
    .DEBOUNCE_CYCLES(D),
    .BLINK_HALF_CYCLES(BH)
  ) dut (
    .clk_p(clk_p),
    .clk_n(clk_n),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 begin
    clk_p = ~clk_p;
    clk_n = ~clk_n;
  end

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_dbd = '0;
    m_on = '0; m_led = '0; m_evt = '0;
    m_pre = 0; m_ph = 1'b0;
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    edge_num = 0;
    exp_q.delete();
  endtask

  // Reference behaviour for one active clock edge, computed from pre-edge values.
  task automatic model_step();
    logic [3:0] rise, on_n, led_n, old_db, old_s1;
    logic       ph_n;
    logic [1:0] md;
    rise   = m_db & ~m_dbd;
    old_db = m_db;
    old_s1 = m_s1;
    ph_n   = (m_pre == BH - 1) ? ~m_ph : m_ph;
    m_pre  = (m_pre == BH - 1) ? 0 : m_pre + 1;
    for (int c = 0; c < N; c++) begin
      md = bus.mode[2*c +: 2];
      if (md == 2'b11)      on_n[c] = 1'b0;
      else if (md == 2'b01) on_n[c] = m_on[c];
      else                  on_n[c] = m_on[c] ^ rise[c];
      case (md)
        2'b00:   led_n[c] = on_n[c];
        2'b01:   led_n[c] = old_db[c];
        2'b10:   led_n[c] = on_n[c] & ph_n;
        default: led_n[c] = 1'b0;
      endcase
      if (m_s2[c] == old_db[c]) begin
        m_cnt[c] = 0;
      end else if (m_cnt[c] == D - 1) begin
        m_db[c]  = m_s2[c];
        m_cnt[c] = 0;
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
    m_dbd = old_db;
    m_s2  = old_s1;
    m_s1  = bus.push;
    m_on  = on_n;
    m_led = led_n;
    m_evt = rise;
    m_ph  = ph_n;
    edge_num++;
    exp_q.push_back('{led: m_led, on: m_on, evt: m_evt});
  endtask

  task automatic check_output(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] p, input logic [7:0] m);
    bus.push = p;
    bus.mode = m;
  endtask

  task automatic set_reset(input logic v);
    @(negedge clk_p);
    #2 rst_n = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_p);
  endtask

  task automatic wait_edge(input int n);
    int budget = 2000;
    while (edge_num < n && budget > 0) begin
      @(negedge clk_p);
      budget--;
    end
    if (edge_num != n) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_edge: reached edge %0d, wanted %0d", edge_num, n);
    end
  endtask

  function automatic logic blink_ph(input int e);
    return logic'((e / BH) % 2);
  endfunction

  initial begin
    forever begin
      @(posedge clk_p or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Scoreboard: each edge's expectation is consumed at the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_p);
      if (!rst_n) begin
        check_output("reset_outputs_zero",
                     {bus.led_on, bus.on_state, bus.push_evt}, 12'h000);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("scoreboard", {bus.led_on, bus.on_state, bus.push_evt}, e);
      end
    end
  end

  initial begin
    for (int c = 0; c < N; c++) evt_cnt[c] = 0;
    forever begin
      @(posedge clk_p);
      for (int c = 0; c < N; c++) evt_cnt[c] += int'(bus.push_evt[c]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with every button already held.
    apply_stimulus(4'hF, 8'h00);
    wait_cycles(3);
    check_output("rst_hold", {bus.led_on, bus.on_state, bus.push_evt}, 12'h000);
    set_reset(1'b1);
    wait_edge(D + 2);
    check_output("rst_evt_before", {8'h00, bus.push_evt}, 12'h000);
    wait_edge(D + 3);
    check_output("rst_evt_all", {8'h00, bus.push_evt}, 12'h00F);
    check_output("rst_on_all", {8'h00, bus.on_state}, 12'h00F);
    wait_edge(D + 4);
    check_output("rst_evt_single", {8'h00, bus.push_evt}, 12'h000);

    // Toggle on channel 0.
    apply_stimulus(4'h0, 8'h00);
    set_reset(1'b0);
    wait_cycles(2);
    apply_stimulus(4'b0001, 8'h00);
    set_reset(1'b1);
    wait_edge(6);
    check_output("tog_led_e6", {8'h00, bus.led_on}, 12'h000);
    wait_edge(7);
    check_output("tog_led_e7", {8'h00, bus.led_on}, 12'h001);
    check_output("tog_evt_e7", {8'h00, bus.push_evt}, 12'h001);
    wait_edge(10);
    apply_stimulus(4'b0000, 8'h00);
    wait_edge(20);
    check_output("tog_release_hold", {4'h0, bus.led_on, bus.on_state}, 12'h011);
    apply_stimulus(4'b0001, 8'h00);
    wait_edge(26);
    check_output("tog2_led_e6", {8'h00, bus.led_on}, 12'h001);
    wait_edge(27);
    check_output("tog2_led_e7", {8'h00, bus.led_on}, 12'h000);
    check_output("tog2_evt_e7", {8'h00, bus.push_evt}, 12'h001);

    // Bouncing on channel 1, then a clean hold.
    wait_edge(30);
    snap = evt_cnt[1];
    for (int k = 0; k < 10; k++) begin
      apply_stimulus({2'b00, ~bus.push[1], 1'b1}, 8'h00);
      wait_cycles(2);
    end
    apply_stimulus(4'b0011, 8'h00);
    base = edge_num;
    wait_edge(base + 6);
    check_output("bounce_no_evt", {8'h00, bus.push_evt}, 12'h000);
    check_output("bounce_cnt_before", 12'(evt_cnt[1] - snap), 12'd0);
    wait_edge(base + 7);
    check_output("bounce_evt", {8'h00, bus.push_evt}, 12'h002);
    check_output("bounce_on", {11'h000, bus.on_state[1]}, 12'h001);
    wait_edge(base + 15);
    check_output("bounce_cnt_after", 12'(evt_cnt[1] - snap), 12'd1);

    // Channel 2 in blink mode.
    apply_stimulus(4'b0111, 8'h20);
    base = edge_num;
    wait_edge(base + 7);
    check_output("blink_on", {11'h000, bus.on_state[2]}, 12'h001);
    for (int k = 0; k < 20; k++) begin
      check_output("blink_wave", {11'h000, bus.led_on[2]}, {11'h000, blink_ph(edge_num)});
      @(negedge clk_p);
    end

    // Channel 2 momentary, then forced off.
    apply_stimulus(4'b0111, 8'h10);
    wait_cycles(1);
    check_output("mom_led_held", {10'h000, bus.led_on[2], bus.on_state[2]}, 12'h003);
    apply_stimulus(4'b0011, 8'h10);
    base = edge_num;
    wait_edge(base + 6);
    check_output("mom_rel_e6", {11'h000, bus.led_on[2]}, 12'h001);
    wait_edge(base + 7);
    check_output("mom_rel_e7", {10'h000, bus.led_on[2], bus.on_state[2]}, 12'h001);
    apply_stimulus(4'b0111, 8'h10);
    base = edge_num;
    wait_edge(base + 7);
    check_output("mom_press_e7", {11'h000, bus.led_on[2]}, 12'h001);
    apply_stimulus(4'b0111, 8'h30);
    wait_cycles(1);
    check_output("off_forced", {10'h000, bus.led_on[2], bus.on_state[2]}, 12'h000);

    // Simultaneous presses with modes 00/01/10/11 on channels 0..3.
    apply_stimulus(4'h0, 8'h00);
    set_reset(1'b0);
    wait_cycles(2);
    apply_stimulus(4'b0010, 8'h00);
    set_reset(1'b1);
    wait_edge(7);
    check_output("sim_pre_on", {8'h00, bus.on_state}, 12'h002);
    wait_edge(8);
    apply_stimulus(4'b0000, 8'h00);
    wait_edge(16);
    apply_stimulus(4'hF, 8'hE4);
    base = edge_num;
    wait_edge(base + 6);
    check_output("sim_evt_before", {8'h00, bus.push_evt}, 12'h000);
    wait_edge(base + 7);
    check_output("sim_evt", {8'h00, bus.push_evt}, 12'h00F);
    check_output("sim_on", {8'h00, bus.on_state}, 12'h007);
    check_output("sim_led", {8'h00, bus.led_on}, {8'h00, 1'b0, blink_ph(edge_num), 2'b11});

    // Reset asserted part-way through a debounce.
    apply_stimulus(4'h0, 8'h00);
    set_reset(1'b0);
    wait_cycles(2);
    set_reset(1'b1);
    wait_edge(3);
    apply_stimulus(4'b0001, 8'h00);
    snap = evt_cnt[0];
    wait_edge(6);
    set_reset(1'b0);
    wait_cycles(2);
    check_output("mid_rst_outputs", {bus.led_on, bus.on_state, bus.push_evt}, 12'h000);
    check_output("mid_rst_no_evt", 12'(evt_cnt[0] - snap), 12'd0);
    set_reset(1'b1);
    wait_edge(D + 2);
    check_output("mid_rel_e6", {8'h00, bus.push_evt}, 12'h000);
    check_output("mid_rel_cnt", 12'(evt_cnt[0] - snap), 12'd0);
    wait_edge(D + 3);
    check_output("mid_rel_evt", {8'h00, bus.push_evt}, 12'h001);
    check_output("mid_rel_on", {8'h00, bus.on_state}, 12'h001);
    wait_edge(D + 5);
    check_output("mid_rel_cnt_one", 12'(evt_cnt[0] - snap), 12'd1);

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
